// File: rtl/clm_pkg.sv
// Column-memory constants and per-word read tag, shared by the read DMA and the responder.
package clm_pkg;
  localparam int CLM_AW    = 16;
  localparam int CLM_DW    = 64;
  localparam int CLM_DEPTH = 4096;

  typedef struct packed {
    logic first;
    logic last;
    logic oor;
  } clm_tag_t;
endpackage

// File: rtl/clm_rd_fifo.sv
// Registered synchronous FIFO; the head is visible the cycle after push and reads as zero when empty.
// No internal backpressure: the caller guarantees it never pushes into a full FIFO.
module clm_rd_fifo #(
  parameter int W = 66,
  parameter int D = 4,
  localparam int PW = (D > 1) ? $clog2(D) : 1,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_dat_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(D));
  assign do_push   = push_i && !full;
  assign do_pop    = pop_i && !empty;
  assign count_o   = cnt_q;
  assign pop_dat_o = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end
endmodule

// File: rtl/clm_rd_resp.sv
// Column-memory read responder: in-order SRAM reads returned with first/last, addr->data latency RL+1.
// addr_ready drops when credits run out, so the SRAM pipeline never stalls on data backpressure.
module clm_rd_resp
  import clm_pkg::*;
#(
  parameter int AW    = CLM_AW,
  parameter int DW    = CLM_DW,
  parameter int DEPTH = CLM_DEPTH,
  parameter int RL    = 1,
  parameter int FD    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          addr_first,
  input  logic          addr_last,
  input  logic          addr_valid,
  output logic          addr_ready,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] data,
  output logic          data_first,
  output logic          data_last,
  output logic          data_valid,
  input  logic          data_ready,
  output logic [1:0]    err
);
  localparam int CW = $clog2(FD + 1);
  localparam int FW = DW + 2;

  logic [CW-1:0] credit_q, credit_d;
  logic          run_q;
  logic          burst_open_q, burst_open_d;
  logic [1:0]    err_q, err_d;
  logic          addr_hs, in_range, pop;
  logic          pipe_vld_q [RL];
  clm_tag_t      pipe_tag_q [RL];
  logic          push;
  logic [FW-1:0] push_dat, head_dat;
  logic [CW-1:0] fifo_count;

  // run_q keeps addr_ready low during reset even though credit resets to FD
  assign addr_ready = run_q && (credit_q != '0);
  assign addr_hs    = addr_valid && addr_ready;
  assign in_range   = ({1'b0, addr} < (AW + 1)'(DEPTH));
  assign mem_ren    = addr_hs && in_range;
  assign mem_addr   = mem_ren ? addr : '0;
  assign data_valid = (fifo_count != '0);
  assign pop        = data_valid && data_ready;
  assign err        = err_q;

  always_comb begin
    credit_d = credit_q;
    if (addr_hs && !pop) credit_d = credit_q - CW'(1);
    else if (!addr_hs && pop) credit_d = credit_q + CW'(1);
  end

  // A violation is a first while open or a non-first while closed, i.e. first == open.
  always_comb begin
    burst_open_d = burst_open_q;
    err_d        = err_q;
    if (addr_hs) begin
      if (!in_range) err_d[0] = 1'b1;
      if (addr_first == burst_open_q) err_d[1] = 1'b1;
      if (addr_last) burst_open_d = 1'b0;
      else if (addr_first) burst_open_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      credit_q     <= CW'(FD);
      burst_open_q <= 1'b0;
      err_q        <= '0;
    end else begin
      run_q        <= 1'b1;
      credit_q     <= credit_d;
      burst_open_q <= burst_open_d;
      err_q        <= err_d;
    end
  end

  // Tag shift register, stage RL-1 lines up with mem_rdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RL; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_tag_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= addr_hs;
      pipe_tag_q[0] <= '{first: addr_first, last: addr_last, oor: !in_range};
      for (int i = 1; i < RL; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  assign push     = pipe_vld_q[RL-1];
  assign push_dat = {pipe_tag_q[RL-1].first, pipe_tag_q[RL-1].last,
                     pipe_tag_q[RL-1].oor ? {DW{1'b0}} : mem_rdata};

  clm_rd_fifo #(
    .W (FW),
    .D (FD)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .pop_dat_o  (head_dat),
    .count_o    (fifo_count)
  );

  assign {data_first, data_last, data} = head_dat;
endmodule

// File: tb/tb_clm_rd_resp.sv
// Scoreboard bench for clm_rd_resp: directed phases plus randomized bursts against a word-level model.
module tb_clm_rd_resp;
  localparam int AW = 16, DW = 64, DEPTH = 4096, RL = 1, FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          addr_first = 1'b0, addr_last = 1'b0, addr_valid = 1'b0;
  logic          addr_ready, mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] data;
  logic          data_first, data_last, data_valid;
  logic          data_ready = 1'b0;
  logic [1:0]    err;

  typedef struct {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } word_t;

  word_t         exp_q[$];
  int            hs_cyc[$], pop_cyc[$];
  int            checks = 0, errors = 0, cyc = 0, ovf = 0;
  int            n0, p0;
  logic [1:0]    exp_err = 2'b00;
  bit            open_m = 0, prev_stall = 0, rnd_rdy = 0, bp_done = 0;
  logic [DW+1:0] prev_out = '0;
  logic [DW-1:0] rpipe [RL];
  logic [AW-1:0] bp_base;
  int            bp_n;

  clm_rd_resp #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RL(RL), .FD(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .addr_first (addr_first),
    .addr_last  (addr_last),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .data       (data),
    .data_first (data_first),
    .data_last  (data_last),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return DW'(a) * 3;
  endfunction

  // SRAM model: fixed latency RL, garbage on the bus when not reading
  always @(posedge clk) begin
    rpipe[0] <= mem_ren ? memval(mem_addr) : {$urandom, $urandom};
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RL-1];

  task automatic chk(input string nm, input logic [DW+7:0] act, input logic [DW+7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    word_t w;
    bit    hs;
    if (!rst_n) begin
      exp_q.delete();
      exp_err    = 2'b00;
      open_m     = 0;
      prev_stall = 0;
      chk("rst_data_valid", data_valid, 0);
      chk("rst_addr_ready", addr_ready, 0);
      chk("rst_outputs", {data_first, data_last, data}, 0);
      chk("rst_mem", {mem_ren, mem_addr}, 0);
      chk("rst_err", err, 0);
    end else begin
      hs = addr_valid && addr_ready;
      chk("mem_ren", mem_ren, hs && (addr < DEPTH));
      if (hs && (addr < DEPTH)) chk("mem_addr", mem_addr, addr);
      chk("err", err, exp_err);
      if (prev_stall) chk("stall_hold", {data_valid, data_first, data_last, data}, {1'b1, prev_out});
      if (data_valid && data_ready) begin
        pop_cyc.push_back(cyc);
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("word", {data_first, data_last, data}, {w.f, w.l, w.d});
        end
      end
      prev_stall = data_valid && !data_ready;
      prev_out   = {data_first, data_last, data};
      if (hs) begin
        hs_cyc.push_back(cyc);
        w.d = (addr < DEPTH) ? memval(addr) : '0;
        w.f = addr_first;
        w.l = addr_last;
        exp_q.push_back(w);
        if (addr >= DEPTH) exp_err[0] = 1'b1;
        if (addr_first ? open_m : !open_m) exp_err[1] = 1'b1;
        open_m = addr_last ? 0 : (addr_first ? 1 : open_m);
      end
      if (dut.u_fifo.push_i && dut.u_fifo.count_o == FD) ovf++;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_rdy) data_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input bit f, input bit l);
    int n = 0;
    addr = a; addr_first = f; addr_last = l; addr_valid = 1'b1;
    @(negedge clk);
    while (!addr_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!addr_ready) chk("send_timeout", addr_ready, 1);
    @(posedge clk);
    #1;
    addr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || data_valid) && n < 5000) begin
      tick(1);
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", data_valid, 0);
  endtask

  task automatic bp_test(input logic [AW-1:0] base, input int n);
    int h0;
    bp_base = base; bp_n = n; bp_done = 0;
    data_ready = 1'b0;
    h0 = hs_cyc.size();
    fork
      begin
        for (int i = 0; i < bp_n; i++) send(bp_base + AW'(i), i == 0, i == bp_n - 1);
        bp_done = 1;
      end
    join_none
    tick(12);
    chk("bp_accepted", hs_cyc.size() - h0, FD);
    chk("bp_ready_low", addr_ready, 0);
    data_ready = 1'b1;
    for (int k = 0; k < 400 && !bp_done; k++) tick(1);
    chk("bp_sends_done", bp_done, 1);
    drain();
    chk("bp_total", hs_cyc.size() - h0, n);
  endtask

  initial begin
    int sent, len;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("ready_after_reset", addr_ready, 1);

    // single burst 0x10..0x13
    data_ready = 1'b1;
    n0 = hs_cyc.size(); p0 = pop_cyc.size();
    for (int i = 0; i < 4; i++) send(AW'('h10 + i), i == 0, i == 3);
    drain();
    chk("burst_words", pop_cyc.size() - p0, 4);
    if (pop_cyc.size() - p0 >= 4) begin
      chk("first_latency", pop_cyc[p0] - hs_cyc[n0], RL + 1);
      chk("burst_back_to_back", pop_cyc[p0+3] - pop_cyc[p0], 3);
    end
    chk("burst_err", err, 2'b00);

    bp_test(AW'('h100), 8);

    // out of range single-word burst
    send(AW'('h1000), 1, 1);
    drain();
    chk("oor_err", err, 2'b01);

    // two firsts without a last, then close and a legal single-word burst
    send(AW'('h20), 1, 0);
    send(AW'('h21), 1, 0);
    send(AW'('h22), 0, 1);
    send(AW'('h30), 1, 1);
    drain();
    chk("proto_err", err, 2'b11);

    // reset with words in flight
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(AW'('h40 + i), i == 0, i == 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", data_valid, 0);
    chk("rst_mid_ready", addr_ready, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_mid_ready_after", addr_ready, 1);
    bp_test(AW'('h50), 6);

    // random bursts with 50% data_ready
    rnd_rdy = 1;
    sent = 0;
    while (sent < 1000) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        send(AW'($urandom_range(0, 4300)), i == 0, i == len - 1);
        sent++;
        if ($urandom_range(0, 7) == 0) tick($urandom_range(1, 3));
      end
    end
    tick(1);
    rnd_rdy = 0;
    data_ready = 1'b1;
    drain();

    // sustained streaming with data_ready held high
    n0 = hs_cyc.size(); p0 = pop_cyc.size();
    for (int i = 0; i < 40; i++) send(AW'(i * 7), i == 0, i == 39);
    drain();
    chk("stream_count", pop_cyc.size() - p0, 40);
    if (hs_cyc.size() - n0 >= 40 && pop_cyc.size() - p0 >= 40) begin
      chk("stream_issue_rate", hs_cyc[n0+39] - hs_cyc[n0], 39);
      chk("stream_return_rate", pop_cyc[p0+39] - pop_cyc[p0], 39);
    end

    chk("fifo_overflow", ovf, 0);
    chk("leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule

// File: doc/clm_rd_resp.md
Name: clm_rd_resp

Overview:
Responder (memory side) of the column-memory read address/data interface driven by the convolution read DMA.
- Accepts a stream of word addresses tagged with first/last over a valid/ready handshake.
- Reads a single-port synchronous SRAM with fixed latency and returns the read words in order, with first/last re-aligned to each word, over a valid/ready data stream.
- A credit-limited output FIFO absorbs downstream backpressure so that the SRAM pipeline never stalls.

Parameters:
AW, 16, address width in words.
DW, 64, data width.
DEPTH, 4096, number of valid SRAM words; addresses >= DEPTH are out of range.
RL, 1, SRAM read latency in cycles (>= 1).
FD, 4, output FIFO depth; must be >= RL+2 for full throughput.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
addr  in  AW  requested word address.
addr_first  in  1  first address of a burst.
addr_last  in  1  last address of a burst.
addr_valid  in  1  address valid.
addr_ready  out  1  address accepted.
mem_ren  out  1  SRAM read enable.
mem_addr  out  AW  SRAM address.
mem_rdata  in  DW  SRAM read data, valid RL cycles after mem_ren.
data  out  DW  returned word.
data_first  out  1  word belongs to first address of burst.
data_last  out  1  word belongs to last address of burst.
data_valid  out  1  returned word valid.
data_ready  in  1  consumer ready.
err  out  2  sticky flags: [0] out-of-range address, [1] first/last protocol violation.

Behaviour:
- Reset (async assert, sync release): data_valid=0, data/data_first/data_last=0, mem_ren=0, mem_addr=0, err=0, addr_ready=0 while rst_n low. Credit counter=FD. FIFO and pipeline are emptied.
- Reset mid-operation discards all in-flight reads and FIFO contents. No partial burst is completed.
- Credit: credit = FD - (fifo_count + inflight), held as a registered counter.
  - addr_ready = (credit != 0).
  - Handshake decrements credit; FIFO pop (data_valid & data_ready) increments it.
  - Both in the same cycle: no change. A pop frees credit visible next cycle.
- Issue: on an addr handshake in cycle t:
  - If addr < DEPTH: mem_ren=1 and mem_addr=addr in the same cycle (combinational from the handshake).
  - Otherwise mem_ren=0, the word is returned as all-zero and err[0] is set.
- Tag pipeline: RL stages carrying {valid, first, last, oor}, aligned with mem_rdata.
  - At stage RL, the word (mem_rdata, or 0 if oor) and its tags are pushed into the FIFO.
  - The push can never overflow, guaranteed by credit. An overflow is a design bug; the bench asserts on it.
- Output: FIFO head drives data/data_first/data_last; data_valid = FIFO non-empty.
  - Registered FIFO gives minimum latency addr handshake t -> data_valid at t+RL+1 (t+2 at default).
  - Output holds stable while data_valid & !data_ready.
- Ordering: strictly in order; one data word per accepted address. first/last are passed through unmodified.
- Protocol check: a burst_open flag sets on an accepted first and clears on an accepted last.
  - err[1] sets on: first while open, non-first while closed.
  - A single-word burst (first & last) is legal.
  - The violating word is still serviced normally.
- Throughput: with data_ready held high and FD >= RL+2, one address accepted and one word returned per cycle sustained.
- err bits clear only on reset.
- Counter widths: credit is clog2(FD+1) bits. The credit arithmetic never wraps.

Decomposition:
- Shared package clm_pkg holds the CLM_AW, CLM_DW and CLM_DEPTH constants and the tag typedef {first, last, oor}. The package is shared with the read DMA.
- One sub-module, clm_rd_fifo: synchronous FIFO of FD x (DW+2) with push/pop/count and the same async active-low reset.
- Credit logic, tag pipeline and protocol checker stay in clm_rd_resp.

Test Plan:
- Single burst: addr 0x10..0x13 (first on 0x10, last on 0x13), data_ready=1, SRAM preloaded mem[a]=a*3 -> data 0x30,0x33,0x36,0x39 on 4 consecutive cycles, first on word 0, last on word 3, first data 2 cycles after first handshake, err=0.
- Backpressure: 8-address burst with data_ready=0 -> exactly FD=4 addresses accepted, then addr_ready=0. Release data_ready -> all 8 words return in order with no loss or duplication, and data stays stable while stalled.
- Out of range: DEPTH=4096, single burst addr 0x1000 (first & last) -> mem_ren stays 0, data=0 with first=last=1, err=2'b01.
- Protocol: two consecutive firsts without a last -> err[1]=1, both words still returned. A following legal single-word burst is serviced correctly.
- Reset mid-burst: assert rst_n low with 3 words in flight/FIFO -> data_valid=0 immediately, addr_ready=0. After release addr_ready=1 with credit=FD and no stale words ever appear.
- Random: 1000 random addresses with random burst lengths and random data_ready at 50% -> scoreboard matches order, first/last and data; throughput is 1/cycle whenever data_ready is held high for 20+ cycles.
